// File: rtl/counter_display_driver.sv
// counter_display_driver
// Samples the 4-bit counter value and shows it as two decimal digits on a
// time-multiplexed, active-low seven-segment display with the leading zero
// blanked. The displayed value is latched once per frame so both digits
// always come from the same sample.
// Optional build macro: COUNTER_DISPLAY_MONITOR_EN compiles in the count
// monitor (STEP/WRAP/WRAP_CNT/ERR); without it those outputs are tied low.

module counter_display_driver #(
   parameter int REFRESH_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] q_i,
   output logic [6:0] seg_o,
   output logic [1:0] an_o,
   output logic       step_o,
   output logic       wrap_o,
   output logic [7:0] wrap_cnt_o,
   output logic       err_o
);

   localparam int DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

   typedef enum logic {
      SLOT_UNITS = 1'b0,
      SLOT_TENS  = 1'b1
   } slot_t;

   logic [3:0]      qSync_q;
   logic [DivW-1:0] divCnt_q, divCnt_d;
   slot_t           slot_q, slot_d;
   logic [3:0]      qHold_q, qHold_d;
   logic [6:0]      seg_q, seg_d;
   logic [1:0]      an_q, an_d;

   logic       divTerm;
   logic       tensDigit;
   logic [3:0] unitsVal;

   function automatic logic [6:0] segCode(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = 7'b1000000;
         4'd1:    code = 7'b1111001;
         4'd2:    code = 7'b0100100;
         4'd3:    code = 7'b0110000;
         4'd4:    code = 7'b0011001;
         4'd5:    code = 7'b0010010;
         4'd6:    code = 7'b0000010;
         4'd7:    code = 7'b1111000;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0010000;
         default: code = 7'b1111111;
      endcase
      return code;
   endfunction

   // Next-state for the scan divider, the slot selector and the frame-latched value
   always_comb begin
      divTerm   = (divCnt_q == DivLast);
      divCnt_d  = divTerm ? '0 : divCnt_q + 1'b1;
      slot_d    = slot_q;
      qHold_d   = qHold_q;
      if (divTerm) begin
         slot_d = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
         if (slot_q == SLOT_TENS) begin
            qHold_d = qSync_q;
         end
      end
   end

   // Split the held value into digits and pick segment/anode drive for the current slot
   always_comb begin
      tensDigit = (qHold_q >= 4'd10);
      unitsVal  = tensDigit ? (qHold_q - 4'd10) : qHold_q;
      seg_d     = 7'b1111111;
      an_d      = 2'b11;
      if (slot_q == SLOT_UNITS) begin
         seg_d = segCode(unitsVal);
         an_d  = 2'b10;
      end else if (tensDigit) begin
         seg_d = segCode(4'd1);
         an_d  = 2'b01;
      end
   end

   // Input sync stage, scan state and registered display outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         qSync_q  <= 4'd0;
         divCnt_q <= '0;
         slot_q   <= SLOT_UNITS;
         qHold_q  <= 4'd0;
         seg_q    <= 7'b1111111;
         an_q     <= 2'b11;
      end else begin
         qSync_q  <= q_i;
         divCnt_q <= divCnt_d;
         slot_q   <= slot_d;
         qHold_q  <= qHold_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;

`ifdef COUNTER_DISPLAY_MONITOR_EN
   logic       syncValid_q;
   logic       prevValid_q;
   logic [3:0] prev_q;
   logic       step_q, wrap_q, err_q;
   logic [7:0] wrapCnt_q;

   logic changed, isWrap, illegal;

   // Classify the transition between the previous and current synchronised samples
   always_comb begin
      changed = prevValid_q && (qSync_q != prev_q);
      isWrap  = changed && (prev_q == 4'd15) && (qSync_q == 4'd0);
      illegal = changed && (qSync_q != (prev_q + 4'd1));
   end

   // History is only trusted once the sync stage holds a real sample, so the
   // reset value of the sync register is never compared against live data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         syncValid_q <= 1'b0;
         prevValid_q <= 1'b0;
         prev_q      <= 4'd0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
         wrapCnt_q   <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         syncValid_q <= 1'b1;
         prevValid_q <= syncValid_q;
         prev_q      <= qSync_q;
         step_q      <= changed;
         wrap_q      <= isWrap;
         if (isWrap && (wrapCnt_q != 8'hFF)) begin
            wrapCnt_q <= wrapCnt_q + 8'd1;
         end
         if (illegal) begin
            err_q <= 1'b1;
         end
      end
   end

   assign step_o     = step_q;
   assign wrap_o     = wrap_q;
   assign wrap_cnt_o = wrapCnt_q;
   assign err_o      = err_q;
`else
   assign step_o     = 1'b0;
   assign wrap_o     = 1'b0;
   assign wrap_cnt_o = 8'h00;
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_display_driver.sv
// Testbench for counter_display_driver (REFRESH_DIV = 4).
// Display expectations are queued per frame when the frame's value is
// sampled and compared on every cycle of each slot; monitor events are
// queued when a new counter value is driven and compared when due.

module tb_counter_display_driver;

   localparam int R = 4;

   logic       clk;
   logic       rst;
   logic [3:0] q_i;
   logic [6:0] seg_o;
   logic [1:0] an_o;
   logic       step_o;
   logic       wrap_o;
   logic [7:0] wrap_cnt_o;
   logic       err_o;

   counter_display_driver #(.REFRESH_DIV(R)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .q_i        (q_i),
      .seg_o      (seg_o),
      .an_o       (an_o),
      .step_o     (step_o),
      .wrap_o     (wrap_o),
      .wrap_cnt_o (wrap_cnt_o),
      .err_o      (err_o)
   );

   typedef struct {
      int unsigned due;
      bit          wrap;
      bit          err;
   } monEv_t;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   bit          active = 0;
   logic [3:0]  lastVal = 4'd0;
   logic [8:0]  dispQ[$];
   monEv_t      monQ[$];
   logic [8:0]  cur = 9'h1FF;
   bit          expErr = 0;
   logic [7:0]  expWrapCnt = 8'd0;
   int unsigned stepSeen = 0;
   int unsigned wrapSeen = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expectation and tallies the result
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
      end
   endtask

   function automatic logic [6:0] refSeg(input int d);
      logic [6:0] table_v [10];
      table_v = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return table_v[d];
   endfunction

   // Queues the units slot and tens slot expected for a frame showing value v
   task automatic pushFrame(input logic [3:0] v);
      int val;
      val = int'(v);
      dispQ.push_back({refSeg(val % 10), 2'b10});
      if (val >= 10) dispQ.push_back({refSeg(1), 2'b01});
      else           dispQ.push_back({7'b1111111, 2'b11});
   endtask

   // Per-cycle scoreboard: display slots, frame sampling and monitor events
   initial begin
      logic [3:0] qSeen;
      logic       rstSeen;
      bit         expStep, expWrap;
      monEv_t     ev;
      forever begin
         @(posedge clk);
         qSeen   = q_i;
         rstSeen = rst;
         #1;
         if (rstSeen) begin
            cyc = 0;
            dispQ.delete();
            monQ.delete();
            pushFrame(4'd0);
            expErr     = 0;
            expWrapCnt = 8'd0;
         end else if (active) begin
            cyc++;
            if (((cyc - 1) % (2 * R) == 0) || ((cyc - 1) % (2 * R) == R)) begin
               if (dispQ.size() > 0) cur = dispQ.pop_front();
               else checkOutput("sbUnderflow", 32'd0, 32'd1);
            end
            checkOutput("display", {23'd0, seg_o, an_o}, {23'd0, cur});
            if ((cyc + 1) % (2 * R) == 0) pushFrame(qSeen);
            expStep = 0;
            expWrap = 0;
            if (monQ.size() > 0 && monQ[0].due == cyc) begin
               ev      = monQ.pop_front();
               expStep = 1;
               expWrap = ev.wrap;
               if (ev.wrap && expWrapCnt != 8'hFF) expWrapCnt = expWrapCnt + 8'd1;
               if (ev.err) expErr = 1;
            end
            if (step_o === 1'b1) stepSeen++;
            if (wrap_o === 1'b1) wrapSeen++;
`ifdef COUNTER_DISPLAY_MONITOR_EN
            checkOutput("step", {31'd0, step_o}, {31'd0, expStep});
            checkOutput("wrap", {31'd0, wrap_o}, {31'd0, expWrap});
            checkOutput("err", {31'd0, err_o}, {31'd0, expErr});
            checkOutput("wrapCnt", {24'd0, wrap_cnt_o}, {24'd0, expWrapCnt});
`else
            checkOutput("stepTied", {31'd0, step_o}, 32'd0);
            checkOutput("wrapTied", {31'd0, wrap_o}, 32'd0);
            checkOutput("errTied", {31'd0, err_o}, 32'd0);
            checkOutput("wrapCntTied", {24'd0, wrap_cnt_o}, 32'd0);
`endif
         end
      end
   end

   // Asserts reset between clock edges, checks the immediate reset values, then releases
   task automatic doReset(input logic [3:0] v);
      @(negedge clk);
      q_i     = v;
      lastVal = v;
      rst     = 1'b1;
      #1;
      checkOutput("rstSeg", {25'd0, seg_o}, {25'd0, 7'b1111111});
      checkOutput("rstAn", {30'd0, an_o}, {30'd0, 2'b11});
      checkOutput("rstErr", {31'd0, err_o}, 32'd0);
      checkOutput("rstWrapCnt", {24'd0, wrap_cnt_o}, 32'd0);
      active = 1;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      stepSeen = 0;
      wrapSeen = 0;
   endtask

   // Drives a new counter value and queues the monitor event it should cause
   task automatic applyStimulus(input logic [3:0] v);
      monEv_t ev;
      logic [3:0] nextVal;
      @(negedge clk);
      if (v != lastVal) begin
         nextVal = lastVal + 4'd1;
         ev.due  = cyc + 2;
         ev.wrap = (lastVal == 4'd15) && (v == 4'd0);
         ev.err  = (v != nextVal);
         monQ.push_back(ev);
      end
      lastVal = v;
      q_i     = v;
   endtask

   initial begin
      bit found;
      rst = 1'b0;
      q_i = 4'd0;

      // Single digit with blanked tens
      doReset(4'd5);
      repeat (20) @(negedge clk);

      // Two digits, tens slot shows "1"
      applyStimulus(4'd13);
      repeat (24) @(negedge clk);

      // Change during the units slot must not tear the frame
      applyStimulus(4'd2);
      repeat (24) @(negedge clk);
      found = 0;
      for (int i = 0; i < 4 * R && !found; i++) begin
         if (cyc % (2 * R) == 1) found = 1;
         else @(negedge clk);
      end
      checkOutput("unitsSlotFound", {31'd0, found}, 32'd1);
      applyStimulus(4'd9);
      repeat (24) @(negedge clk);

      // Legal stepping across the wrap
      doReset(4'd14);
      repeat (4) @(negedge clk);
      applyStimulus(4'd15);
      repeat (2) @(negedge clk);
      applyStimulus(4'd0);
      repeat (2) @(negedge clk);
      applyStimulus(4'd1);
      repeat (10) @(negedge clk);
`ifdef COUNTER_DISPLAY_MONITOR_EN
      checkOutput("stepPulses", stepSeen, 32'd3);
      checkOutput("wrapPulses", wrapSeen, 32'd1);
      checkOutput("wrapCntFinal", {24'd0, wrap_cnt_o}, 32'd1);
`else
      checkOutput("stepPulses", stepSeen, 32'd0);
      checkOutput("wrapPulses", wrapSeen, 32'd0);
      checkOutput("wrapCntFinal", {24'd0, wrap_cnt_o}, 32'd0);
`endif
      checkOutput("errAfterLegal", {31'd0, err_o}, 32'd0);

      // Illegal jump sets the sticky error
      doReset(4'd3);
      repeat (4) @(negedge clk);
      applyStimulus(4'd7);
      repeat (3) @(negedge clk);
      applyStimulus(4'd8);
      repeat (10) @(negedge clk);
`ifdef COUNTER_DISPLAY_MONITOR_EN
      checkOutput("errSticky", {31'd0, err_o}, 32'd1);
`else
      checkOutput("errSticky", {31'd0, err_o}, 32'd0);
`endif

      // Mid-frame reset clears everything immediately
      repeat (3) @(negedge clk);
      doReset(4'd0);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
